// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: port count, scoreboard id width,
// exception record and the writeback payload handed to the scoreboard.
package wb_arbiter_pkg;
  localparam int NR_WB_PORTS   = 4;
  localparam int TRANS_ID_BITS = 2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               ex;
  } wb_entry_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: per-port requester handshake in, one registered result out.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NR_PORTS = NR_WB_PORTS
);
  logic [NR_PORTS-1:0]            valid_i;
  logic [NR_PORTS-1:0]            ready_o;
  wb_entry_t [NR_PORTS-1:0]       wb_i;
  logic                           wb_valid_o;
  wb_entry_t                      wb_o;
  logic                           wb_ready_i;

  modport slave  (input  valid_i, wb_i, wb_ready_i,
                  output ready_o, wb_valid_o, wb_o);
  modport master (output valid_i, wb_i, wb_ready_i,
                  input  ready_o, wb_valid_o, wb_o);
endinterface

// File: rtl/wb_arbiter_rr_select.sv
// Combinational round-robin pick: first set req bit at or after start_i, wrapping.
module wb_arbiter_rr_select
  import wb_arbiter_pkg::*;
#(
  parameter int NR_PORTS = NR_WB_PORTS,
  parameter int IDX_W    = idx_w(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]    start_i,
  output logic [NR_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                any_o
);
  always_comb begin
    int j;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = 0; k < NR_PORTS; k++) begin
      j = int'(start_i) + k;
      if (j >= NR_PORTS) j = j - NR_PORTS;
      if (!any_o && req_i[j]) begin
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
        any_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one functional-unit result per cycle into a
// single output register feeding the scoreboard write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NR_PORTS = NR_WB_PORTS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  wb_arbiter_if.slave   bus
);
  localparam int IDX_W = idx_w(NR_PORTS);

  logic [IDX_W-1:0]    rr_q, rr_d, gnt_idx;
  logic [NR_PORTS-1:0] gnt;
  logic                any, grant_en, xfer;
  logic                wb_valid_q, wb_valid_d;
  wb_entry_t           wb_q, wb_d;

  wb_arbiter_rr_select #(.NR_PORTS(NR_PORTS), .IDX_W(IDX_W)) i_sel (
    .req_i     (bus.valid_i),
    .start_i   (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  // Grants also masked during reset so nothing looks accepted while clearing.
  assign grant_en    = rst_ni & ~flush_i & (~wb_valid_q | bus.wb_ready_i);
  assign bus.ready_o = grant_en ? gnt : '0;
  assign xfer        = grant_en & any;

  always_comb begin
    rr_d       = rr_q;
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    if (xfer) begin
      wb_d       = bus.wb_i[gnt_idx];
      wb_valid_d = 1'b1;
      rr_d       = (gnt_idx == IDX_W'(NR_PORTS-1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (flush_i || bus.wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign bus.wb_valid_o = wb_valid_q;
  assign bus.wb_o       = wb_q;

  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.ready_o));
  a_rdy_vld: assert property (@(posedge clk_i) disable iff (!rst_ni) (bus.ready_o & ~bus.valid_i) == '0);
  a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
                           (wb_valid_q && !bus.wb_ready_i) |=> $stable(wb_q));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: table of per-cycle stimulus and
// expected grant/output, plus a fairness sweep under full contention.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic [3:0] v;
    logic [7:0] ids;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_vld;
    int         e_src;   // -1 skip payload, 4 all-zero, else source port
    logic [1:0] e_tid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, flush;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] res [4];
  exception_t  exc [4];
  vec_t        vecs [27];

  wb_arbiter_if #(.NR_PORTS(4)) bus ();

  wb_arbiter #(.NR_PORTS(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] v, input logic [7:0] ids, input logic rdy);
    rst_n          = r;
    flush          = f;
    bus.valid_i    = v;
    bus.wb_ready_i = rdy;
    for (int p = 0; p < 4; p++) begin
      bus.wb_i[p].trans_id = ids[2*p +: 2];
      bus.wb_i[p].result   = res[p];
      bus.wb_i[p].ex       = exc[p];
    end
  endtask

  initial begin
    vec_t      cur;
    wb_entry_t exp_wb;
    logic [3:0] mask;

    res[0] = 64'h0123_4567_89AB_CDEF;
    res[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    res[2] = 64'h0000_0000_DEAD_BEEF;
    res[3] = 64'h8000_0000_0000_0001;
    for (int p = 0; p < 3; p++) exc[p] = '0;
    exc[3] = '{cause: 64'h5, tval: 64'h1234, valid: 1'b1};

    //            rst   fl    v     ids    rdy   e_rdy e_vld src tid
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h0, 1'b0,  4, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h1, 1'b0,  4, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h2, 1'b1,  0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h4, 1'b1,  1, 2'd1};
    vecs[4]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h8, 1'b1,  2, 2'd2};
    vecs[5]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h1, 1'b1,  3, 2'd3};
    vecs[6]  = '{1'b1, 1'b0, 4'h4, 8'hB4, 1'b1, 4'h4, 1'b1,  0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 8'hB4, 1'b1, 4'h0, 1'b1,  2, 2'd3};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 8'hE4, 1'b1, 4'h0, 1'b0, -1, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 4'h8, 8'hE4, 1'b1, 4'h8, 1'b0, -1, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 4'h5, 8'hE4, 1'b1, 4'h1, 1'b1,  3, 2'd3};
    vecs[11] = '{1'b1, 1'b0, 4'h4, 8'hE4, 1'b1, 4'h4, 1'b1,  0, 2'd0};
    vecs[12] = '{1'b1, 1'b0, 4'h2, 8'hE4, 1'b1, 4'h2, 1'b1,  2, 2'd2};
    vecs[13] = '{1'b1, 1'b0, 4'h8, 8'hE4, 1'b0, 4'h0, 1'b1,  1, 2'd1};
    vecs[14] = '{1'b1, 1'b0, 4'h8, 8'hE4, 1'b0, 4'h0, 1'b1,  1, 2'd1};
    vecs[15] = '{1'b1, 1'b0, 4'h8, 8'hE4, 1'b0, 4'h0, 1'b1,  1, 2'd1};
    vecs[16] = '{1'b1, 1'b0, 4'h8, 8'hE4, 1'b1, 4'h8, 1'b1,  1, 2'd1};
    vecs[17] = '{1'b1, 1'b0, 4'h0, 8'hE4, 1'b0, 4'h0, 1'b1,  3, 2'd3};
    vecs[18] = '{1'b1, 1'b1, 4'h2, 8'hE4, 1'b0, 4'h0, 1'b1,  3, 2'd3};
    vecs[19] = '{1'b1, 1'b0, 4'h2, 8'hE4, 1'b0, 4'h2, 1'b0, -1, 2'd0};
    vecs[20] = '{1'b1, 1'b1, 4'hF, 8'hE4, 1'b1, 4'h0, 1'b1,  1, 2'd1};
    vecs[21] = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h4, 1'b0, -1, 2'd0};
    vecs[22] = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 4'h8, 1'b1,  2, 2'd2};
    vecs[23] = '{1'b0, 1'b1, 4'hF, 8'hE4, 1'b1, 4'h0, 1'b1,  3, 2'd3};
    vecs[24] = '{1'b1, 1'b0, 4'hE, 8'hE4, 1'b1, 4'h2, 1'b0,  4, 2'd0};
    vecs[25] = '{1'b1, 1'b0, 4'h0, 8'hE4, 1'b1, 4'h0, 1'b1,  1, 2'd1};
    vecs[26] = '{1'b1, 1'b0, 4'h0, 8'hE4, 1'b1, 4'h0, 1'b0, -1, 2'd0};

    // First reset edge; vecs[0] supplies the second.
    drive(1'b0, 1'b0, 4'hF, 8'hE4, 1'b1);
    @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      cur = vecs[i];
      #1;
      drive(cur.rst_n, cur.fl, cur.v, cur.ids, cur.rdy);
      @(negedge clk);
      chk("ready_o", i, 256'(bus.ready_o), 256'(cur.e_rdy));
      chk("wb_valid_o", i, 256'(bus.wb_valid_o), 256'(cur.e_vld));
      if (cur.e_src >= 0) begin
        if (cur.e_src == 4) exp_wb = '0;
        else exp_wb = '{trans_id: cur.e_tid, result: res[cur.e_src], ex: exc[cur.e_src]};
        chk("wb_o", i, 256'(bus.wb_o), 256'(exp_wb));
      end
      @(posedge clk);
    end

    // Fairness: all ports requesting, every port served within NR_PORTS grants.
    mask = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      drive(1'b1, 1'b0, 4'hF, 8'hE4, 1'b1);
      @(negedge clk);
      chk("fair_onehot", 100 + c, 256'($countones(bus.ready_o)), 256'(1));
      mask = mask | bus.ready_o;
      @(posedge clk);
    end
    chk("fair_all_served", 104, 256'(mask), 256'(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
